// File: rtl/beat_scheduler.sv
// Beat scheduler: play/pause/stop sequencing, tempo-scaled beat timing and
// step strobes for the tone/LED step decoder.
module beat_scheduler #(
   parameter int unsigned BASE_TICK = 12_500_000,
   parameter int unsigned TICK_STEP = 1_000_000,
   parameter int unsigned BEAT_MAX  = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        play_pulse,
   input  logic        stop_pulse,
   input  logic        tempo_up_pulse,
   input  logic        tempo_down_pulse,
   input  logic        loop_mode,
   output logic [11:0] ibeat_num,
   output logic        en,
   output logic [3:0]  step,
   output logic        step_strobe,
   output logic [1:0]  state,
   output logic [2:0]  tempo_level
);

   localparam int unsigned TICK_W  = 32;
   localparam int unsigned BEAT_W  = 12;
   localparam int unsigned TEMPO_W = 3;

   typedef enum logic [1:0] {
      ST_STOP  = 2'b00,
      ST_PLAY  = 2'b01,
      ST_PAUSE = 2'b10,
      ST_END   = 2'b11
   } state_t;

   state_t              state_q, state_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [TICK_W-1:0]   period_q, period_d;
   logic [TICK_W-1:0]   pend_period;
   logic [BEAT_W-1:0]   beat_q, beat_d, beat_inc;
   logic                strobe_q, strobe_d;
   logic                en_q;
   logic [TEMPO_W-1:0]  tempo_q, tempo_d;

   // Period that the next beat will use, derived from the live tempo level.
   assign pend_period = TICK_W'(BASE_TICK) - (TICK_W'(tempo_q) * TICK_W'(TICK_STEP));
   assign beat_inc    = beat_q + BEAT_W'(1);

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_STOP;
         tick_q   <= '0;
         period_q <= TICK_W'(BASE_TICK);
         beat_q   <= '0;
         strobe_q <= 1'b0;
         en_q     <= 1'b0;
         tempo_q  <= '0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         period_q <= period_d;
         beat_q   <= beat_d;
         strobe_q <= strobe_d;
         en_q     <= (state_d == ST_PLAY) || (state_d == ST_END);
         tempo_q  <= tempo_d;
      end
   end

   // Next-state and beat/tick sequencing; stop takes priority over everything.
   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      period_d = period_q;
      beat_d   = beat_q;
      strobe_d = 1'b0;
      if (stop_pulse) begin
         state_d = ST_STOP;
         tick_d  = '0;
         beat_d  = '0;
      end else begin
         case (state_q)
            ST_STOP, ST_END: begin
               if (play_pulse) begin
                  state_d  = ST_PLAY;
                  tick_d   = '0;
                  beat_d   = '0;
                  period_d = pend_period;
                  strobe_d = 1'b1;
               end
            end
            ST_PLAY: begin
               if (play_pulse) begin
                  state_d = ST_PAUSE;
               end else if (tick_q == (period_q - TICK_W'(1))) begin
                  // Beat boundary: latch the new period so tempo changes never
                  // stretch or shrink a beat already in progress.
                  tick_d   = '0;
                  period_d = pend_period;
                  if (beat_q == BEAT_W'(BEAT_MAX - 1)) begin
                     if (loop_mode) begin
                        beat_d   = '0;
                        strobe_d = 1'b1;
                     end else begin
                        state_d = ST_END;
                        beat_d  = BEAT_W'(BEAT_MAX);
                     end
                  end else begin
                     beat_d   = beat_inc;
                     strobe_d = (beat_inc[1:0] == 2'b00);
                  end
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
            ST_PAUSE: begin
               if (play_pulse) state_d = ST_PLAY;
            end
            default: state_d = ST_STOP;
         endcase
      end
   end

   // Saturating tempo level; simultaneous up and down cancel.
   always_comb begin
      tempo_d = tempo_q;
      if (tempo_up_pulse && !tempo_down_pulse && (tempo_q != TEMPO_W'(7)))
         tempo_d = tempo_q + TEMPO_W'(1);
      else if (tempo_down_pulse && !tempo_up_pulse && (tempo_q != TEMPO_W'(0)))
         tempo_d = tempo_q - TEMPO_W'(1);
   end

   assign ibeat_num   = beat_q;
   assign step        = beat_q[5:2];
   assign step_strobe = strobe_q;
   assign en          = en_q;
   assign state       = state_q;
   assign tempo_level = tempo_q;

endmodule

// File: tb/tb_beat_scheduler.sv
// Directed self-checking bench for beat_scheduler (BASE_TICK=10, TICK_STEP=1, BEAT_MAX=8).
module tb_beat_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        play_pulse, stop_pulse, tempo_up_pulse, tempo_down_pulse, loop_mode;
   logic [11:0] ibeat_num;
   logic        en;
   logic [3:0]  step;
   logic        step_strobe;
   logic [1:0]  state;
   logic [2:0]  tempo_level;

   int checks = 0;
   int errors = 0;

   beat_scheduler #(.BASE_TICK(10), .TICK_STEP(1), .BEAT_MAX(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .play_pulse       (play_pulse),
      .stop_pulse       (stop_pulse),
      .tempo_up_pulse   (tempo_up_pulse),
      .tempo_down_pulse (tempo_down_pulse),
      .loop_mode        (loop_mode),
      .ibeat_num        (ibeat_num),
      .en               (en),
      .step             (step),
      .step_strobe      (step_strobe),
      .state            (state),
      .tempo_level      (tempo_level)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_play();
      play_pulse = 1'b1;
      cyc(1);
      play_pulse = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      play_pulse = 1'b0; stop_pulse = 1'b0;
      tempo_up_pulse = 1'b0; tempo_down_pulse = 1'b0;
      loop_mode = 1'b1;
      cyc(3);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_beat", 32'(ibeat_num), 32'd0);
      chk("rst_en", 32'(en), 32'd0);
      chk("rst_strobe", 32'(step_strobe), 32'd0);
      chk("rst_tempo", 32'(tempo_level), 32'd0);
      rst = 1'b0;
      cyc(2);

      // Start and first beat timing
      pulse_play();
      chk("start_state", 32'(state), 32'd1);
      chk("start_en", 32'(en), 32'd1);
      chk("start_beat", 32'(ibeat_num), 32'd0);
      chk("start_strobe", 32'(step_strobe), 32'd1);
      cyc(9);
      chk("beat0_hold", 32'(ibeat_num), 32'd0);
      chk("no_strobe_mid", 32'(step_strobe), 32'd0);
      cyc(1);
      chk("beat1_at10", 32'(ibeat_num), 32'd1);
      chk("no_strobe_beat1", 32'(step_strobe), 32'd0);

      // Step boundary at beat 4, loop wrap at cycle 80
      cyc(30);
      chk("beat4_at40", 32'(ibeat_num), 32'd4);
      chk("strobe_beat4", 32'(step_strobe), 32'd1);
      chk("step_beat4", 32'(step), 32'd1);
      cyc(39);
      chk("beat7_at79", 32'(ibeat_num), 32'd7);
      cyc(1);
      chk("wrap_beat", 32'(ibeat_num), 32'd0);
      chk("wrap_strobe", 32'(step_strobe), 32'd1);
      chk("wrap_state", 32'(state), 32'd1);

      // Stop
      stop_pulse = 1'b1; cyc(1); stop_pulse = 1'b0;
      chk("stop_state", 32'(state), 32'd0);
      chk("stop_beat", 32'(ibeat_num), 32'd0);
      chk("stop_en", 32'(en), 32'd0);

      // Play-once ends in END with out-of-range beat
      loop_mode = 1'b0;
      pulse_play();
      cyc(80);
      chk("end_state", 32'(state), 32'd3);
      chk("end_beat", 32'(ibeat_num), 32'd8);
      chk("end_en", 32'(en), 32'd1);
      chk("end_strobe", 32'(step_strobe), 32'd0);
      pulse_play();
      chk("restart_state", 32'(state), 32'd1);
      chk("restart_beat", 32'(ibeat_num), 32'd0);
      chk("restart_strobe", 32'(step_strobe), 32'd1);

      // Pause at beat 3 tick 5, resume
      cyc(35);
      chk("pre_pause_beat", 32'(ibeat_num), 32'd3);
      pulse_play();
      chk("pause_state", 32'(state), 32'd2);
      chk("pause_en", 32'(en), 32'd0);
      cyc(20);
      chk("pause_hold_beat", 32'(ibeat_num), 32'd3);
      chk("pause_hold_state", 32'(state), 32'd2);
      pulse_play();
      chk("resume_state", 32'(state), 32'd1);
      chk("resume_no_strobe", 32'(step_strobe), 32'd0);
      chk("resume_beat", 32'(ibeat_num), 32'd3);
      cyc(4);
      chk("resume_beat_hold", 32'(ibeat_num), 32'd3);
      cyc(1);
      chk("resume_beat4", 32'(ibeat_num), 32'd4);
      chk("resume_strobe4", 32'(step_strobe), 32'd1);

      // Tempo raised mid-beat: current beat keeps 10 cycles, next is 3
      cyc(1);
      tempo_up_pulse = 1'b1; cyc(8); tempo_up_pulse = 1'b0;
      chk("tempo_max", 32'(tempo_level), 32'd7);
      chk("tempo_beat_hold", 32'(ibeat_num), 32'd4);
      cyc(1);
      chk("tempo_beat5", 32'(ibeat_num), 32'd5);
      cyc(2);
      chk("fast_beat_hold", 32'(ibeat_num), 32'd5);
      cyc(1);
      chk("fast_beat6", 32'(ibeat_num), 32'd6);
      tempo_up_pulse = 1'b1; cyc(1); tempo_up_pulse = 1'b0;
      chk("tempo_sat7", 32'(tempo_level), 32'd7);
      tempo_up_pulse = 1'b1; tempo_down_pulse = 1'b1; cyc(1);
      tempo_up_pulse = 1'b0; tempo_down_pulse = 1'b0;
      chk("tempo_both", 32'(tempo_level), 32'd7);

      // Stop wins over simultaneous play
      play_pulse = 1'b1; stop_pulse = 1'b1; cyc(1);
      play_pulse = 1'b0; stop_pulse = 1'b0;
      chk("stopwin_state", 32'(state), 32'd0);
      chk("stopwin_beat", 32'(ibeat_num), 32'd0);

      // Tempo 6 -> period 4; async reset at beat 5
      tempo_down_pulse = 1'b1; cyc(1); tempo_down_pulse = 1'b0;
      chk("tempo_down", 32'(tempo_level), 32'd6);
      loop_mode = 1'b1;
      pulse_play();
      cyc(20);
      chk("t6_beat5", 32'(ibeat_num), 32'd5);
      #2 rst = 1'b1;
      #1;
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_beat", 32'(ibeat_num), 32'd0);
      chk("arst_en", 32'(en), 32'd0);
      chk("arst_tempo", 32'(tempo_level), 32'd0);
      cyc(1);
      rst = 1'b0;
      cyc(1);

      // Post-reset period back to BASE_TICK; down saturates at 0
      tempo_down_pulse = 1'b1; cyc(1); tempo_down_pulse = 1'b0;
      chk("tempo_sat0", 32'(tempo_level), 32'd0);
      pulse_play();
      cyc(9);
      chk("post_rst_hold", 32'(ibeat_num), 32'd0);
      cyc(1);
      chk("post_rst_beat1", 32'(ibeat_num), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/beat_scheduler.md
BEAT_SCHEDULER -- requirements
Module: beat_scheduler

Interface
REQ-001 The block SHALL have parameter BASE_TICK, default 12_500_000, meaning clk cycles per beat at tempo_level 0.
REQ-002 The block SHALL have parameter TICK_STEP, default 1_000_000, meaning cycles removed from the beat period per tempo_level increment.
REQ-003 The block SHALL have parameter BEAT_MAX, default 64, meaning number of beats in one pattern pass (ibeat_num counts 0..BEAT_MAX-1).
REQ-004 The block SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port play_pulse, input, 1, one-cycle debounced play/pause request.
REQ-007 The block SHALL have port stop_pulse, input, 1, one-cycle debounced stop request.
REQ-008 The block SHALL have ports tempo_up_pulse and tempo_down_pulse, input, 1 each, one-cycle tempo change requests.
REQ-009 The block SHALL have port loop_mode, input, 1; 1 = repeat the pattern, 0 = play once.
REQ-010 The block SHALL have port ibeat_num, output, 12, current beat index driving the tone/LED step decoder.
REQ-011 The block SHALL have port en, output, 1, play enable for the step decoder.
REQ-012 The block SHALL have port step, output, 4, current step = ibeat_num[5:2].
REQ-013 The block SHALL have port step_strobe, output, 1, one-cycle pulse on entry to each new step.
REQ-014 The block SHALL have port state, output, 2, STOP=00, PLAY=01, PAUSE=10, END=11.
REQ-015 The block SHALL have port tempo_level, output, 3, current tempo 0..7.

Function
REQ-016 All outputs SHALL be registered; beat period SHALL be BASE_TICK - tempo_level*TICK_STEP cycles, computed at 32 bits.
REQ-017 STOP + play_pulse SHALL enter PLAY next cycle with ibeat_num=0, tick counter=0, step_strobe=1 for that cycle.
REQ-018 PLAY + play_pulse SHALL enter PAUSE; tick counter and ibeat_num SHALL hold.
REQ-019 PAUSE + play_pulse SHALL return to PLAY resuming from held tick count and ibeat_num; no step_strobe.
REQ-020 stop_pulse in any state SHALL enter STOP with ibeat_num=0 and tick counter=0; if play_pulse is simultaneous, stop wins.
REQ-021 In PLAY the tick counter SHALL count 0..period-1; on the cycle it equals period-1 it SHALL clear and ibeat_num SHALL increment.
REQ-022 Advance from ibeat_num=BEAT_MAX-1 with loop_mode=1 SHALL wrap to 0 and stay in PLAY.
REQ-023 Advance from ibeat_num=BEAT_MAX-1 with loop_mode=0 SHALL enter END with ibeat_num=BEAT_MAX (decoder out-of-range: silence, all LEDs).
REQ-024 END + play_pulse SHALL behave as STOP + play_pulse (REQ-017).
REQ-025 step_strobe SHALL pulse for one cycle whenever ibeat_num changes to a multiple of 4 below BEAT_MAX in PLAY, including wrap to 0.
REQ-026 en SHALL be 1 in PLAY and END, 0 in STOP and PAUSE.
REQ-027 tempo_up_pulse SHALL increment tempo_level saturating at 7; tempo_down_pulse SHALL decrement saturating at 0; both together SHALL leave it unchanged.
REQ-028 Tempo changes SHALL be accepted in any state but the new period SHALL apply only from the next tick-counter clear (or next start from 0); a running beat is never shortened or lengthened.
REQ-029 loop_mode SHALL be sampled only at the BEAT_MAX-1 advance.

Reset
REQ-030 rst SHALL asynchronously force state=STOP, ibeat_num=0, tick counter=0, step_strobe=0, en=0, tempo_level=0, pending period = BASE_TICK, including mid-PLAY.

Verification (BASE_TICK=10, TICK_STEP=1, BEAT_MAX=8)
REQ-031 Reset then play_pulse -> next cycle state=01, en=1, ibeat_num=0, step_strobe=1; ibeat_num=1 exactly 10 cycles later.
REQ-032 loop_mode=1, run 80 cycles after start -> ibeat_num wraps 7->0 at cycle 80 with step_strobe=1, state stays 01.
REQ-033 loop_mode=0, run 80 cycles -> state=11, ibeat_num=8, en=1; play_pulse -> state=01, ibeat_num=0.
REQ-034 play at beat 3 tick 5, pause 20 cycles, resume -> ibeat_num=4 exactly 5 cycles after resume, no strobe on resume.
REQ-035 Eight tempo_up_pulses mid-beat -> tempo_level=7, current beat keeps 10 cycles, next beat lasts 3 cycles; simultaneous play_pulse+stop_pulse -> state=00, ibeat_num=0.
REQ-036 rst asserted mid-PLAY at ibeat_num=5 -> immediately state=00, ibeat_num=0, en=0, tempo_level=0.
